vic_arbiter: RTL and testbench

Parametrised vectored interrupt arbiter and controller. It latches per-source requests, with edge or level mode per source and per-source mask, and selects the highest-priority pending source (lowest index wins). It presents one registered vector to the CPU and runs an ack/EOI handshake. A single non-vectored request is served only when no vectored source is eligible. It sits between the peripheral IRQ lines plus the non-vectored IRQ unit and the CPU interrupt entry logic.

---
 rtl/vic_pkg.sv | 13 +
 rtl/vic_prio_enc.sv | 23 ++
 rtl/vic_arbiter.sv | 132 +++++++++++++
 tb/tb_vic_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt arbiter.
package vic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } vic_state_t;

    localparam int unsigned VIC_MAX_SRC = 64;
    localparam int unsigned VIC_NV_VEC  = 0;

endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-index-first priority encoder; idx is zero when nothing is requesting.
module vic_prio_enc #(
    parameter  int unsigned NUM_SRC = 16,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vic_arbiter.sv
// Vectored interrupt arbiter: per-source edge/level latching, masking, fixed
// priority, and a registered request/ack/EOI handshake towards the CPU.
module vic_arbiter
    import vic_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 16,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               nv_req_i,
    input  logic [NUM_SRC-1:0] cfg_mask_i,
    input  logic [NUM_SRC-1:0] cfg_edge_i,
    input  logic               irq_ack_i,
    input  logic               eoi_i,
    output logic               irq_o,
    output logic [IDX_W-1:0]   vec_o,
    output logic               is_nv_o,
    output logic               in_service_o,
    output logic [NUM_SRC-1:0] pend_o
);

    vic_state_t         state_q;
    vic_state_t         state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_clr;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               presented_ok;
    logic               ack_vec;
    logic               irq_d;
    logic [IDX_W-1:0]   vec_d;
    logic               is_nv_d;
    logic               in_service_d;

    assign eligible     = pend_q & cfg_mask_i;
    assign rise         = src_i & ~src_q;
    assign presented_ok = is_nv_o ? nv_req_i : eligible[vec_o];
    assign pend_o       = pend_q;

    vic_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Edge sources: a new edge beats a same-cycle ack clear. Level sources track the line.
    always_comb begin
        ack_clr = '0;
        if (ack_vec) begin
            ack_clr[vec_o] = 1'b1;
        end
        pend_d = (cfg_edge_i & (rise | (pend_q & ~ack_clr))) | (~cfg_edge_i & src_i);
    end

    // Next-state and next-output logic for the CPU handshake.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_o;
        vec_d        = vec_o;
        is_nv_d      = is_nv_o;
        in_service_d = in_service_o;
        ack_vec      = 1'b0;

        case (state_q)
            IDLE: begin
                irq_d = 1'b0;
                if (win_valid) begin
                    vec_d   = win_idx;
                    is_nv_d = 1'b0;
                    irq_d   = 1'b1;
                    state_d = REQ;
                end else if (nv_req_i) begin
                    vec_d   = IDX_W'(VIC_NV_VEC);
                    is_nv_d = 1'b1;
                    irq_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack outranks a same-cycle withdraw; the presented vector is frozen.
                if (irq_ack_i) begin
                    state_d      = SVC;
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                    ack_vec      = ~is_nv_o;
                end else if (!presented_ok) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            end
            SVC: begin
                if (eoi_i) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            pend_q       <= '0;
            irq_o        <= 1'b0;
            vec_o        <= '0;
            is_nv_o      <= 1'b0;
            in_service_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_i;
            pend_q       <= pend_d;
            irq_o        <= irq_d;
            vec_o        <= vec_d;
            is_nv_o      <= is_nv_d;
            in_service_o <= in_service_d;
        end
    end

endmodule

// File: tb/tb_vic_arbiter.sv
// Bench for vic_arbiter: directed handshake scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the interrupt rules.
module tb_vic_arbiter;

    localparam int unsigned NUM_SRC = 16;
    localparam int unsigned IDX_W   = $clog2(NUM_SRC);

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] src_i;
    logic               nv_req_i;
    logic [NUM_SRC-1:0] cfg_mask_i;
    logic [NUM_SRC-1:0] cfg_edge_i;
    logic               irq_ack_i;
    logic               eoi_i;
    logic               irq_o;
    logic [IDX_W-1:0]   vec_o;
    logic               is_nv_o;
    logic               in_service_o;
    logic [NUM_SRC-1:0] pend_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: "presenting" / "servicing" flags, chosen vector, pending set, last src.
    bit                 m_irq;
    bit                 m_nv;
    bit                 m_insvc;
    int                 m_vec;
    logic [NUM_SRC-1:0] m_pend;
    logic [NUM_SRC-1:0] m_prev;

    vic_arbiter #(.NUM_SRC(NUM_SRC)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_i        (src_i),
        .nv_req_i     (nv_req_i),
        .cfg_mask_i   (cfg_mask_i),
        .cfg_edge_i   (cfg_edge_i),
        .irq_ack_i    (irq_ack_i),
        .eoi_i        (eoi_i),
        .irq_o        (irq_o),
        .vec_o        (vec_o),
        .is_nv_o      (is_nv_o),
        .in_service_o (in_service_o),
        .pend_o       (pend_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_irq   = 1'b0;
        m_nv    = 1'b0;
        m_insvc = 1'b0;
        m_vec   = 0;
        m_pend  = '0;
        m_prev  = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int                 win;
        bit                 still_wanted;
        logic [NUM_SRC-1:0] np;
        win = -1;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (m_pend[i] && cfg_mask_i[i]) begin
                win = i;
                break;
            end
        end
        still_wanted = m_nv ? nv_req_i : (m_pend[m_vec] && cfg_mask_i[m_vec]);
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (cfg_edge_i[i]) begin
                np[i] = m_pend[i];
                if (m_irq && irq_ack_i && !m_nv && m_vec == i) np[i] = 1'b0;
                if (src_i[i] && !m_prev[i]) np[i] = 1'b1;
            end else begin
                np[i] = src_i[i];
            end
        end
        if (m_irq) begin
            if (irq_ack_i) begin
                m_irq   = 1'b0;
                m_insvc = 1'b1;
            end else if (!still_wanted) begin
                m_irq = 1'b0;
            end
        end else if (m_insvc) begin
            if (eoi_i) m_insvc = 1'b0;
        end else if (win >= 0) begin
            m_irq = 1'b1;
            m_vec = win;
            m_nv  = 1'b0;
        end else if (nv_req_i) begin
            m_irq = 1'b1;
            m_vec = 0;
            m_nv  = 1'b1;
        end
        m_pend = np;
        m_prev = src_i;
    endtask

    task automatic check_outputs();
        check("irq_o",        64'(irq_o),        64'(m_irq));
        check("vec_o",        64'(vec_o),        64'(m_vec));
        check("is_nv_o",      64'(is_nv_o),      64'(m_nv));
        check("in_service_o", 64'(in_service_o), 64'(m_insvc));
        check("pend_o",       64'(pend_o),       64'(m_pend));
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs sampled likewise.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic serve();
        irq_ack_i = 1'b1;
        cycle();
        irq_ack_i = 1'b0;
        eoi_i     = 1'b1;
        cycle();
        eoi_i = 1'b0;
    endtask

    function automatic logic [NUM_SRC-1:0] rand_bits(input int unsigned one_in);
        logic [NUM_SRC-1:0] v;
        for (int i = 0; i < int'(NUM_SRC); i++) v[i] = ($urandom_range(one_in - 1, 0) == 0);
        return v;
    endfunction

    initial begin
        rst        = 1'b1;
        src_i      = '0;
        nv_req_i   = 1'b0;
        cfg_mask_i = '1;
        cfg_edge_i = '1;
        irq_ack_i  = 1'b0;
        eoi_i      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq",   64'(irq_o),        64'd0);
        check("rst_vec",   64'(vec_o),        64'd0);
        check("rst_nv",    64'(is_nv_o),      64'd0);
        check("rst_insvc", 64'(in_service_o), 64'd0);
        check("rst_pend",  64'(pend_o),       64'd0);
        rst = 1'b0;
        cycle();

        // Two edge sources rise together: lower index first, the other after EOI.
        src_i = 16'h0024;
        cycle();
        cycle();
        check("tp1_irq", 64'(irq_o), 64'd1);
        check("tp1_vec", 64'(vec_o), 64'd2);
        irq_ack_i = 1'b1;
        cycle();
        check("tp1_pend_after_ack", 64'(pend_o), 64'h20);
        irq_ack_i = 1'b0;
        eoi_i     = 1'b1;
        cycle();
        eoi_i = 1'b0;
        cycle();
        check("tp1_vec_second", 64'(vec_o), 64'd5);
        src_i = '0;
        serve();
        cycle();

        // Level source withdrawn before ack.
        cfg_edge_i[3] = 1'b0;
        src_i = 16'h0008;
        cycle();
        cycle();
        check("tp2_vec", 64'(vec_o), 64'd3);
        src_i = '0;
        cycle();
        cycle();
        check("tp2_irq_drop",  64'(irq_o),     64'd0);
        check("tp2_pend3",     64'(pend_o[3]), 64'd0);
        cfg_edge_i[3] = 1'b1;
        cycle();

        // Non-vectored request holds its slot while a vectored edge arrives.
        nv_req_i = 1'b1;
        cycle();
        check("tp3_nv",     64'(is_nv_o), 64'd1);
        check("tp3_nv_vec", 64'(vec_o),   64'd0);
        src_i = 16'h0080;
        repeat (3) cycle();
        check("tp3_frozen", 64'(vec_o), 64'd0);
        irq_ack_i = 1'b1;
        cycle();
        irq_ack_i = 1'b0;
        nv_req_i  = 1'b0;
        eoi_i     = 1'b1;
        cycle();
        eoi_i = 1'b0;
        cycle();
        check("tp3_vec7", 64'(vec_o),   64'd7);
        check("tp3_is_v", 64'(is_nv_o), 64'd0);
        src_i = '0;
        serve();
        cycle();

        // Masked source stays pending without raising irq until unmasked.
        cfg_mask_i = 16'hFFEF;
        src_i      = 16'h0010;
        cycle();
        cycle();
        check("tp4_pend4",  64'(pend_o[4]), 64'd1);
        check("tp4_no_irq", 64'(irq_o),     64'd0);
        cfg_mask_i = '1;
        cycle();
        cycle();
        check("tp4_vec4", 64'(vec_o), 64'd4);
        src_i = '0;
        serve();
        cycle();

        // New edge coincides with ack of the same source: stays pending.
        src_i = 16'h0002;
        cycle();
        src_i = '0;
        cycle();
        cycle();
        src_i     = 16'h0002;
        irq_ack_i = 1'b1;
        cycle();
        check("tp5_pend1", 64'(pend_o[1]), 64'd1);
        irq_ack_i = 1'b0;
        eoi_i     = 1'b1;
        cycle();
        eoi_i = 1'b0;
        cycle();
        check("tp5_vec1_again", 64'(vec_o), 64'd1);

        // Asynchronous reset in the middle of service.
        irq_ack_i = 1'b1;
        cycle();
        irq_ack_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("tp6_irq",   64'(irq_o),        64'd0);
        check("tp6_insvc", 64'(in_service_o), 64'd0);
        check("tp6_pend",  64'(pend_o),       64'd0);
        check("tp6_vec",   64'(vec_o),        64'd0);
        model_reset();
        @(posedge clk);
        #1;
        src_i          = 16'h0600;
        cfg_edge_i[10] = 1'b0;
        rst            = 1'b0;
        cycle();
        check("tp6_rebuild", 64'(pend_o), 64'h0600);
        src_i = '0;
        repeat (3) cycle();
        cfg_edge_i = '1;
        repeat (4) cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            src_i = src_i ^ rand_bits(8);
            if ($urandom_range(49, 0) == 0) cfg_mask_i = ~rand_bits(5);
            if ($urandom_range(99, 0) == 0) cfg_edge_i = NUM_SRC'($urandom);
            if ($urandom_range(3, 0) == 0) nv_req_i = ~nv_req_i;
            irq_ack_i = m_irq   ? ($urandom_range(2, 0) == 0) : ($urandom_range(19, 0) == 0);
            eoi_i     = m_insvc ? ($urandom_range(3, 0) == 0) : ($urandom_range(19, 0) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
